// File: rtl/md_sched_if.sv
// EX-stage multiply/divide bus: op/operands in, HI/LO state, busy and the
// stall request back to hazard logic out.
interface md_sched_if;
  logic [3:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_use_d;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  modport master (
    output md_op, a, b, md_use_d,
    input  busy, stall_req, hi, lo, md_out
  );

  modport slave (
    input  md_op, a, b, md_use_d,
    output busy, stall_req, hi, lo, md_out
  );
endinterface

// File: rtl/md_sched.sv
// Fixed-latency multiply/divide scheduler owning HI/LO; raises a stall to
// the hazard unit while an operation is outstanding.
module md_sched #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input logic       clk,
  input logic       reset,
  md_sched_if.slave bus
);
  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } op_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_t              op_q, op_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] mag_a, mag_b, quo_u, rem_u, quo_m, rem_m, quo_s, rem_s;
  logic        issue;

  assign issue = (bus.md_op >= 4'd1) && (bus.md_op <= 4'd4);

  // Signed divide runs on magnitudes so INT_MIN / -1 wraps to INT_MIN, rem 0.
  always_comb begin
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    mag_a  = a_q[31] ? (~a_q + 32'd1) : a_q;
    mag_b  = b_q[31] ? (~b_q + 32'd1) : b_q;
    quo_u  = '0;
    rem_u  = '0;
    quo_m  = '0;
    rem_m  = '0;
    if (b_q != '0) begin
      quo_u = a_q / b_q;
      rem_u = a_q % b_q;
      quo_m = mag_a / mag_b;
      rem_m = mag_a % mag_b;
    end
    quo_s = (a_q[31] ^ b_q[31]) ? (~quo_m + 32'd1) : quo_m;
    rem_s = a_q[31] ? (~rem_m + 32'd1) : rem_m;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        case (bus.md_op)
          OP_MULT, OP_MULTU: begin
            state_d = RUN;
            cnt_d   = CNT_W'(MULT_LAT - 1);
            op_d    = op_t'(bus.md_op);
            a_d     = bus.a;
            b_d     = bus.b;
          end
          OP_DIV, OP_DIVU: begin
            state_d = RUN;
            cnt_d   = CNT_W'(DIV_LAT - 1);
            op_d    = op_t'(bus.md_op);
            a_d     = bus.a;
            b_d     = bus.b;
          end
          OP_MTHI: hi_d = bus.a;
          OP_MTLO: lo_d = bus.a;
          default: ;
        endcase
      end
      RUN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV: begin
              if (b_q != '0) begin
                hi_d = rem_s;
                lo_d = quo_s;
              end
            end
            OP_DIVU: begin
              if (b_q != '0) begin
                hi_d = rem_u;
                lo_d = quo_u;
              end
            end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.stall_req = bus.md_use_d & ((state_q == RUN) | issue);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.md_out    = (bus.md_op == OP_MFHI) ? hi_q :
                         (bus.md_op == OP_MFLO) ? lo_q : '0;
endmodule

// File: tb/tb_md_sched.sv
// Bench for md_sched: a cycles-remaining model of the unit is compared with
// the DUT every falling edge, plus literal checks of hand-computed results.
module tb_md_sched;
  localparam int unsigned MULT_LAT = 5;
  localparam int unsigned DIV_LAT  = 10;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  md_sched_if bus ();

  md_sched #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_result(input logic [3:0] op,
                                               input logic [31:0] x, y, hi0, lo0);
    longint p;
    int     q, r;
    case (op)
      4'd1: begin
        p = longint'($signed(x)) * longint'($signed(y));
        return p;
      end
      4'd2: return {32'd0, x} * {32'd0, y};
      4'd3: begin
        if (y == 32'd0) return {hi0, lo0};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {r, q};
      end
      4'd4: begin
        if (y == 32'd0) return {hi0, lo0};
        return {x % y, x / y};
      end
      default: return {hi0, lo0};
    endcase
  endfunction

  // Model: count of busy cycles still owed, result applied as it reaches 0.
  int          m_left = 0;
  logic [3:0]  m_op   = '0;
  logic [31:0] m_a    = '0;
  logic [31:0] m_b    = '0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left <= 0;
      m_op   <= '0;
      m_a    <= '0;
      m_b    <= '0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) {m_hi, m_lo} <= model_result(m_op, m_a, m_b, m_hi, m_lo);
    end else begin
      case (bus.md_op)
        4'd1, 4'd2, 4'd3, 4'd4: begin
          m_left <= (bus.md_op <= 4'd2) ? MULT_LAT : DIV_LAT;
          m_op   <= bus.md_op;
          m_a    <= bus.a;
          m_b    <= bus.b;
        end
        4'd5: m_hi <= bus.a;
        4'd6: m_lo <= bus.a;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    logic exp_busy;
    logic is_md;
    exp_busy = (m_left > 0);
    is_md    = (bus.md_op >= 4'd1) && (bus.md_op <= 4'd4);
    check("busy", bus.busy, exp_busy);
    check("stall_req", bus.stall_req, bus.md_use_d & (exp_busy | is_md));
    check("hi", bus.hi, m_hi);
    check("lo", bus.lo, m_lo);
    check("md_out", bus.md_out,
          (bus.md_op == 4'd7) ? m_hi : (bus.md_op == 4'd8) ? m_lo : 32'd0);
  end

  // Called at a falling edge with the unit idle; returns at the falling edge
  // of the first idle cycle so the next op can issue back-to-back.
  task automatic run_op(input logic [3:0] op, input logic [31:0] aa, bb,
                        input logic ud, input logic [3:0] intr_op,
                        input logic [31:0] intr_a, output int nbusy);
    #1;
    bus.md_op    = op;
    bus.a        = aa;
    bus.b        = bb;
    bus.md_use_d = ud;
    #1 check("stall_issue", bus.stall_req, ud);
    @(posedge clk);
    #1 bus.md_op = 4'd0;
    nbusy = 0;
    repeat (40) begin
      @(negedge clk);
      if (!bus.busy) break;
      nbusy++;
      if (intr_op != 4'd0 && nbusy == 2) begin
        #1;
        bus.md_op = intr_op;
        bus.a     = intr_a;
      end
      if (intr_op != 4'd0 && nbusy == 3) #1 bus.md_op = 4'd0;
    end
    if (ud) check("stall_after", bus.stall_req, 1'b0);
  endtask

  task automatic move_to(input logic [3:0] op, input logic [31:0] val, input logic ud);
    #1;
    bus.md_op    = op;
    bus.a        = val;
    bus.md_use_d = ud;
    #1 check("stall_mt", bus.stall_req, 1'b0);
    @(posedge clk);
    #1 bus.md_op = 4'd0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nb;
    bus.md_op    = 4'd0;
    bus.a        = '0;
    bus.b        = '0;
    bus.md_use_d = 1'b0;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_stall", bus.stall_req, 1'b0);
    #1 reset = 1'b1;
    @(negedge clk);

    run_op(4'd1, 32'hFFFF_FFFD, 32'd7, 1'b1, 4'd0, 32'd0, nb);
    check("mult_busy", nb, 32'd5);
    check("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo", bus.lo, 32'hFFFF_FFEB);

    run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd0, 32'd0, nb);
    check("multu_busy", nb, 32'd5);
    check("multu_hi", bus.hi, 32'hFFFF_FFFE);
    check("multu_lo", bus.lo, 32'h0000_0001);

    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 4'd0, 32'd0, nb);
    check("div_busy", nb, 32'd10);
    check("div_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_hi", bus.hi, 32'hFFFF_FFFF);

    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 4'd0, 32'd0, nb);
    check("divovf_lo", bus.lo, 32'h8000_0000);
    check("divovf_hi", bus.hi, 32'd0);

    run_op(4'd3, 32'd7, 32'hFFFF_FFFE, 1'b0, 4'd0, 32'd0, nb);
    check("divneg_lo", bus.lo, 32'hFFFF_FFFD);
    check("divneg_hi", bus.hi, 32'd1);

    move_to(4'd5, 32'h0000_ABCD, 1'b1);
    check("mthi_hi", bus.hi, 32'h0000_ABCD);

    move_to(4'd5, 32'h11, 1'b0);
    move_to(4'd6, 32'h22, 1'b0);
    run_op(4'd4, 32'd100, 32'd0, 1'b1, 4'd6, 32'h0000_DEAD, nb);
    check("divz_busy", nb, 32'd10);
    check("divz_hi", bus.hi, 32'h11);
    check("divz_lo", bus.lo, 32'h22);

    #1 bus.md_op = 4'd7;
    #1 check("mfhi", bus.md_out, 32'h11);
    bus.md_op = 4'd8;
    #1 check("mflo", bus.md_out, 32'h22);
    bus.md_op = 4'd9;
    #1 check("md_out_none", bus.md_out, 32'd0);
    bus.md_op = 4'd0;
    @(negedge clk);

    run_op(4'd4, 32'd100, 32'd7, 1'b0, 4'd0, 32'd0, nb);
    check("divu_lo", bus.lo, 32'd14);
    check("divu_hi", bus.hi, 32'd2);

    #1;
    bus.md_op = 4'd3;
    bus.a     = 32'd1000;
    bus.b     = 32'd3;
    @(posedge clk);
    #1 bus.md_op = 4'd0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    #1 check("midrst_busy", bus.busy, 1'b0);
    check("midrst_hi", bus.hi, 32'd0);
    check("midrst_lo", bus.lo, 32'd0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    run_op(4'd2, 32'd2, 32'd3, 1'b1, 4'd0, 32'd0, nb);
    check("post_rst_busy", nb, 32'd5);
    check("post_rst_lo", bus.lo, 32'd6);
    check("post_rst_hi", bus.hi, 32'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
